// File: rtl/nes_ctrl_poller.sv
// Serial NES/SNES pad poller: drives a shared latch and per-port shift clocks,
// samples synchronised data lines and publishes whole button words per poll.
module nes_ctrl_poller #(
  parameter int NUM_CTRL     = 2,
  parameter int NUM_BITS     = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int POLL_PERIOD  = 0,
  parameter int INVERT_DATA  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         poll_req,
  input  logic [NUM_CTRL-1:0]          ctrl_data,
  output logic                         ctrl_latch,
  output logic [NUM_CTRL-1:0]          ctrl_clk,
  output logic [NUM_CTRL*NUM_BITS-1:0] buttons,
  output logic                         buttons_valid,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  // Handshake: poll_req is a one-cycle strobe with no ready; a request (or
  // auto tick) seen while busy is merged into a single pending poll.
  // buttons_valid is a one-cycle strobe with no backpressure.

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [BW-1:0] BITS_ALL   = BW'(NUM_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    GAP    = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                       state;
  logic [PW-1:0]                phase;
  logic [BW-1:0]                bit_cnt;
  logic                         pending;
  logic                         auto_tick;
  logic                         phase_end;
  logic                         last_bit;
  logic [NUM_CTRL-1:0]          sync1;
  logic [NUM_CTRL-1:0]          sync2;
  logic [NUM_CTRL-1:0]          sample;
  logic [NUM_CTRL*NUM_BITS-1:0] shadow;
  logic [NUM_CTRL*NUM_BITS-1:0] shadow_shift;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ctrl_data;
      sync2 <= sync1;
    end
  end

  assign sample = (INVERT_DATA != 0) ? ~sync2 : sync2;

  // First bit shifted in ends up at bit 0 once NUM_BITS samples have arrived.
  always_comb begin
    shadow_shift = shadow;
    for (int p = 0; p < NUM_CTRL; p++) begin
      shadow_shift[p*NUM_BITS +: NUM_BITS] =
        {sample[p], shadow[p*NUM_BITS+1 +: NUM_BITS-1]};
    end
  end

  generate
    if (POLL_PERIOD > 0) begin : g_auto
      localparam int AW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
      localparam logic [AW-1:0] AUTO_LAST = AW'(POLL_PERIOD - 1);
      logic [AW-1:0] auto_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          auto_cnt <= '0;
        end else if (auto_cnt == AUTO_LAST) begin
          auto_cnt <= '0;
        end else begin
          auto_cnt <= auto_cnt + 1'b1;
        end
      end

      assign auto_tick = (auto_cnt == AUTO_LAST);
    end else begin : g_manual
      assign auto_tick = 1'b0;
    end
  endgenerate

  assign phase_end = (phase == PHASE_LAST);
  assign last_bit  = (BW'(bit_cnt + 1'b1) == BITS_ALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= '0;
      bit_cnt       <= '0;
      pending       <= 1'b0;
      ctrl_latch    <= 1'b0;
      ctrl_clk      <= '0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      busy          <= 1'b0;
      shadow        <= '0;
    end else begin
      buttons_valid <= 1'b0;
      if (state != IDLE && (poll_req || auto_tick)) begin
        pending <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (poll_req || pending || auto_tick) begin
            state      <= LATCH;
            ctrl_latch <= 1'b1;
            busy       <= 1'b1;
            pending    <= 1'b0;
            phase      <= '0;
            bit_cnt    <= '0;
          end
        end
        LATCH: begin
          if (phase_end) begin
            phase      <= '0;
            ctrl_latch <= 1'b0;
            state      <= GAP;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        GAP, CLK_LO: begin
          if (phase_end) begin
            phase   <= '0;
            shadow  <= shadow_shift;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              state         <= DONE;
              buttons       <= shadow_shift;
              buttons_valid <= 1'b1;
            end else begin
              state    <= CLK_HI;
              ctrl_clk <= {NUM_CTRL{1'b1}};
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_HI: begin
          if (phase_end) begin
            phase    <= '0;
            ctrl_clk <= '0;
            state    <= CLK_LO;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_ctrl_poller.sv
// Bench for nes_ctrl_poller: manual 2-pad NES poller, auto-polling 16-bit pad,
// and a non-inverting 3-cycle-pulse instance, each with pad models and scoreboards.
module tb_nes_ctrl_poller;

  localparam int P0   = 4;
  localparam int N0   = 8;
  localparam int L0   = 2*P0*N0 + 1;
  localparam int N1   = 16;
  localparam int L1   = 2*4*N1 + 1;
  localparam int PER1 = 200;
  localparam int P2   = 3;
  localparam int N2   = 8;
  localparam int L2   = 2*P2*N2 + 1;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- DUT instances ----------------
  logic        rst0, rst_o;
  logic        req0, req2;
  logic [1:0]  data0, cclk0;
  logic        latch0, valid0, busy0;
  logic [15:0] btn0;
  logic [2:0]  st0;

  logic [0:0]  data1, cclk1;
  logic        latch1, valid1, busy1;
  logic [15:0] btn1;
  logic [2:0]  st1;
  logic        req1;

  logic [0:0]  data2, cclk2;
  logic        latch2, valid2, busy2;
  logic [7:0]  btn2;
  logic [2:0]  st2;

  assign req1 = 1'b0;

  nes_ctrl_poller #(.NUM_CTRL(2), .NUM_BITS(N0), .PULSE_CYCLES(P0), .POLL_PERIOD(0), .INVERT_DATA(1)) dut0 (
    .clk(clk), .rst(rst0), .poll_req(req0), .ctrl_data(data0), .ctrl_latch(latch0), .ctrl_clk(cclk0),
    .buttons(btn0), .buttons_valid(valid0), .busy(busy0), .dbg_state(st0));

  nes_ctrl_poller #(.NUM_CTRL(1), .NUM_BITS(N1), .PULSE_CYCLES(4), .POLL_PERIOD(PER1), .INVERT_DATA(1)) dut1 (
    .clk(clk), .rst(rst_o), .poll_req(req1), .ctrl_data(data1), .ctrl_latch(latch1), .ctrl_clk(cclk1),
    .buttons(btn1), .buttons_valid(valid1), .busy(busy1), .dbg_state(st1));

  nes_ctrl_poller #(.NUM_CTRL(1), .NUM_BITS(N2), .PULSE_CYCLES(P2), .POLL_PERIOD(0), .INVERT_DATA(0)) dut2 (
    .clk(clk), .rst(rst_o), .poll_req(req2), .ctrl_data(data2), .ctrl_latch(latch2), .ctrl_clk(cclk2),
    .buttons(btn2), .buttons_valid(valid2), .busy(busy2), .dbg_state(st2));

  // ---------------- pad models (line low = pressed) ----------------
  logic [7:0]  press0 [2];
  int          idx0 = 0;
  int          clk_rises0 = 0;
  logic [15:0] press1 = 16'h8000;
  int          idx1 = 0;

  always @(posedge latch0 or posedge cclk0[0]) begin
    if (latch0) idx0 = 0;
    else begin
      idx0 = idx0 + 1;
      clk_rises0 = clk_rises0 + 1;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) data0[p] = (idx0 < N0) ? ~press0[p][idx0[2:0]] : 1'b1;
  end

  always @(posedge latch1 or posedge cclk1[0]) begin
    if (latch1) idx1 = 0;
    else idx1 = idx1 + 1;
  end

  always_comb data1[0] = (idx1 < N1) ? ~press1[idx1[3:0]] : 1'b1;

  // ---------------- dut0 reference model + scoreboard ----------------
  logic [15:0] exp0_q[$];
  int          exp0_t[$];
  int          m_start = -1000;
  int          m_done  = -1000;
  bit          m_pend  = 1'b0;

  always @(negedge clk) begin
    int  off;
    bit  e_busy, e_latch, e_clk;
    if (rst0) begin
      m_start = -1000;
      m_done  = -1000;
      m_pend  = 1'b0;
      exp0_q.delete();
      exp0_t.delete();
    end else begin
      off     = cyc - m_start;
      e_busy  = (off >= 1) && (cyc <= m_done);
      e_latch = e_busy && (off <= P0);
      e_clk   = e_busy && (off > 2*P0) && (off <= 2*P0*N0) && (((off - 2*P0 - 1) % (2*P0)) < P0);
      check("dut0_busy", busy0, e_busy);
      check("dut0_latch", latch0, e_latch);
      check("dut0_ctrl_clk", cclk0, {2{e_clk}});
      if (cyc > m_done && (req0 || m_pend)) begin
        m_start = cyc;
        m_done  = cyc + L0;
        m_pend  = 1'b0;
        exp0_q.push_back({press0[1], press0[0]});
        exp0_t.push_back(cyc + L0);
      end else if (cyc <= m_done && req0) begin
        m_pend = 1'b1;
      end
    end
  end

  int valid_cnt0 = 0;
  int last_valid0 = 0;

  always @(negedge clk) begin
    if (!rst0 && valid0) begin
      valid_cnt0++;
      last_valid0 = cyc;
      if (exp0_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut0_unexpected_valid: actual=pulse required=none (cyc %0d)", cyc);
      end else begin
        check("dut0_buttons", btn0, exp0_q.pop_front());
        check("dut0_valid_cycle", cyc, exp0_t.pop_front());
      end
    end
  end

  // ---------------- dut1 (auto) monitor ----------------
  logic [15:0] exp1_q[$];
  int          exp1_t[$];
  logic        latch1_q = 1'b0;
  int          rise1_cnt = 0;
  int          last_rise1 = 0;
  int          rel1 = 0;

  always @(negedge clk) begin
    if (!rst_o) begin
      if (latch1 && !latch1_q) begin
        if (rise1_cnt == 0) check("auto_first_rise", cyc - rel1, PER1);
        else check("auto_rise_period", cyc - last_rise1, PER1);
        rise1_cnt++;
        last_rise1 = cyc;
        exp1_q.push_back(press1);
        exp1_t.push_back(cyc + L1 - 1);
      end
      latch1_q = latch1;
      if (valid1) begin
        if (exp1_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut1_unexpected_valid: actual=pulse required=none (cyc %0d)", cyc);
        end else begin
          check("dut1_buttons", btn1, exp1_q.pop_front());
          check("dut1_valid_cycle", cyc, exp1_t.pop_front());
        end
      end
    end
  end

  // ---------------- dut2 (non-inverting) monitor ----------------
  logic [7:0] exp2_q[$];
  int         exp2_t[$];

  always @(negedge clk) begin
    if (!rst_o && valid2) begin
      if (exp2_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2_unexpected_valid: actual=pulse required=none (cyc %0d)", cyc);
      end else begin
        check("dut2_buttons", btn2, exp2_q.pop_front());
        check("dut2_valid_cycle", cyc, exp2_t.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req_at(input int dut, input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    if (dut == 0) req0 = 1'b1;
    else req2 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req2 = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while ((exp0_q.size() != 0 || m_pend || cyc <= m_done) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dut0_drain_in_time", (n < 400), 1'b1);
  endtask

  task automatic run2(input logic level);
    int n = 0;
    int c;
    data2 = level;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    c = cyc;
    exp2_q.push_back({N2{level}});
    exp2_t.push_back(c + L2);
    req_at(2, c);
    while (exp2_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dut2_done_in_time", (n < 200), 1'b1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int c;
    int vc;
    int kr;
    int ne;
    rst0 = 1'b1;
    rst_o = 1'b1;
    req0 = 1'b0;
    req2 = 1'b0;
    data2 = 1'b0;
    press0[0] = 8'h00;
    press0[1] = 8'h00;
    @(posedge clk);
    #1;
    check("reset_latch", latch0, 1'b0);
    check("reset_ctrl_clk", cclk0, 2'b00);
    check("reset_buttons", btn0, 16'h0000);
    check("reset_valid", valid0, 1'b0);
    check("reset_busy", busy0, 1'b0);
    check("reset_buttons_dut2", btn2, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst_o = 1'b0;
    rel1 = cyc;

    // Reset in the middle of a poll that would produce 0x00FF.
    press0[0] = 8'hFF;
    press0[1] = 8'h00;
    c = cyc;
    req_at(0, c);
    while (cyc < c + 40) begin
      @(posedge clk);
      #1;
    end
    check("midrst_busy_before", busy0, 1'b1);
    #2 rst0 = 1'b1;
    #1;
    check("midrst_latch", latch0, 1'b0);
    check("midrst_ctrl_clk", cclk0, 2'b00);
    check("midrst_buttons", btn0, 16'h0000);
    check("midrst_valid", valid0, 1'b0);
    check("midrst_busy", busy0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    vc = valid_cnt0;
    repeat (100) @(posedge clk);
    #1;
    check("midrst_no_valid_after", valid_cnt0 - vc, 0);
    check("midrst_buttons_held", btn0, 16'h0000);
    c = cyc;
    req_at(0, c);
    drain0();
    check("midrst_recover_buttons", btn0, 16'h00FF);

    // Pad0 low on bits 0 and 3, pad1 idle.
    press0[0] = 8'h09;
    press0[1] = 8'h00;
    c = cyc;
    kr = clk_rises0;
    req_at(0, c);
    drain0();
    check("t1_buttons", btn0, 16'h0009);
    check("t1_valid_offset", last_valid0 - c, L0);
    check("t1_clk_pulses", clk_rises0 - kr, N0 - 1);

    // Two extra requests during one poll merge into exactly one more poll.
    press0[0] = 8'h3C;
    press0[1] = 8'hA5;
    c = cyc;
    vc = valid_cnt0;
    req_at(0, c);
    req_at(0, c + 20);
    req_at(0, c + 30);
    drain0();
    check("t2_valid_pulses", valid_cnt0 - vc, 2);
    check("t2_second_valid_offset", last_valid0 - c, 2*L0 + 1);

    // Randomised polls with random extra requests.
    for (int i = 0; i < 25; i++) begin
      press0[0] = 8'($urandom_range(0, 255));
      press0[1] = 8'($urandom_range(0, 255));
      c = cyc;
      req_at(0, c);
      ne = $urandom_range(0, 2);
      for (int j = 0; j < ne; j++) req_at(0, cyc + $urandom_range(0, 70));
      drain0();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    run2(1'b0);
    run2(1'b1);

    while (rise1_cnt < 5 && cyc < 20000) begin
      @(posedge clk);
      #1;
    end
    check("auto_pulses_seen", (rise1_cnt >= 5), 1'b1);
    check("auto_buttons_final", btn1, 16'h8000);
    check("dut0_queue_empty", exp0_q.size(), 0);
    check("dut2_queue_empty", exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
